// File: rtl/dm_sba_responder.sv
// Bus-side responder for the debug module's system bus access initiator.
// Serves req/gnt/r_valid transactions from a small word-addressed memory with programmable latencies.
module dm_sba_responder #(
    parameter int BusWidth = 32,
    parameter int MemDepth = 16,
    parameter int GntDelay = 0,
    parameter int RspDelay = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  slave_req_i,
    input  logic [BusWidth-1:0]   slave_add_i,
    input  logic                  slave_we_i,
    input  logic [BusWidth-1:0]   slave_wdata_i,
    input  logic [BusWidth/8-1:0] slave_be_i,
    output logic                  slave_gnt_o,
    output logic                  slave_r_valid_o,
    output logic [BusWidth-1:0]   slave_r_rdata_o,
    output logic                  slave_err_o,
    output logic [15:0]           txn_count_o
);
    localparam int BeWidth = BusWidth / 8;
    localparam int OffBits = $clog2(BeWidth);
    localparam int IdxBits = $clog2(MemDepth);
    localparam logic [3:0] GNT_DLY = 4'(GntDelay);
    localparam logic [3:0] RSP_DLY = 4'(RspDelay);

    typedef enum logic [1:0] {IDLE, STALL, RESPOND} state_t;

    state_t              state_reg;
    logic [3:0]          stall_cnt_reg;
    logic [3:0]          rsp_cnt_reg;
    logic                we_reg;
    logic                in_range_reg;
    logic [BusWidth-1:0] rdata_reg;
    logic [15:0]         txn_count_reg;

    logic [IdxBits-1:0]  idx;
    logic                in_range;
    logic                gnt;
    logic                r_valid;
    logic                wr_en;
    logic [BusWidth-1:0] be_mask;
    logic [BusWidth-1:0] mem_words [MemDepth];
    logic                unused_off;

    // Byte offset bits never select data; lanes come from the byte enables.
    assign unused_off = ^slave_add_i[OffBits-1:0];
    assign idx        = slave_add_i[OffBits +: IdxBits];
    assign in_range   = (slave_add_i >> (OffBits + IdxBits)) == '0;
    assign wr_en      = gnt && slave_we_i && in_range;

    // Grant depends on the live request so a dropped request during a stall is never accepted.
    always_comb begin
        gnt = 1'b0;
        case (state_reg)
            IDLE:    gnt = (GntDelay == 0) && slave_req_i;
            STALL:   gnt = slave_req_i && (stall_cnt_reg == GNT_DLY);
            default: gnt = 1'b0;
        endcase
    end

    assign r_valid = (state_reg == RESPOND) && (rsp_cnt_reg == RSP_DLY);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            stall_cnt_reg <= 4'd0;
            rsp_cnt_reg   <= 4'd0;
            we_reg        <= 1'b0;
            in_range_reg  <= 1'b1;
            rdata_reg     <= '0;
            txn_count_reg <= 16'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (slave_req_i) begin
                        if (GntDelay == 0) begin
                            state_reg   <= RESPOND;
                            rsp_cnt_reg <= 4'd1;
                        end else begin
                            state_reg     <= STALL;
                            stall_cnt_reg <= 4'd1;
                        end
                    end
                end
                STALL: begin
                    if (!slave_req_i) begin
                        state_reg     <= IDLE;
                        stall_cnt_reg <= 4'd0;
                    end else if (stall_cnt_reg == GNT_DLY) begin
                        state_reg     <= RESPOND;
                        stall_cnt_reg <= 4'd0;
                        rsp_cnt_reg   <= 4'd1;
                    end else begin
                        stall_cnt_reg <= stall_cnt_reg + 4'd1;
                    end
                end
                RESPOND: begin
                    if (rsp_cnt_reg == RSP_DLY) begin
                        state_reg   <= IDLE;
                        rsp_cnt_reg <= 4'd0;
                    end else begin
                        rsp_cnt_reg <= rsp_cnt_reg + 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Memory is sampled at the grant, so earlier granted writes are visible.
            if (gnt) begin
                we_reg        <= slave_we_i;
                in_range_reg  <= in_range;
                rdata_reg     <= in_range ? mem_words[idx] : '0;
                txn_count_reg <= txn_count_reg + 16'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BeWidth; gi++) begin : g_be
            assign be_mask[gi*8 +: 8] = {8{slave_be_i[gi]}};
        end

        for (gi = 0; gi < MemDepth; gi++) begin : g_word
            logic [BusWidth-1:0] word_reg;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    word_reg <= '0;
                end else if (wr_en && (idx == IdxBits'(gi))) begin
                    word_reg <= (word_reg & ~be_mask) | (slave_wdata_i & be_mask);
                end
            end
            assign mem_words[gi] = word_reg;
        end
    endgenerate

    assign slave_gnt_o     = gnt;
    assign slave_r_valid_o = r_valid;
    assign slave_r_rdata_o = (r_valid && !we_reg) ? rdata_reg : '0;
    assign slave_err_o     = r_valid && !in_range_reg;
    assign txn_count_o     = txn_count_reg;

endmodule

// File: tb/tb_dm_sba_responder.sv
// Directed bench for dm_sba_responder: a zero-latency instance driven from a vector table
// and a GntDelay=3/RspDelay=4 instance exercised by hand-written latency and reset sequences.
module tb_dm_sba_responder;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: GntDelay=0, RspDelay=1
    logic        rst_a, req_a, we_a, gnt_a, r_valid_a, err_a;
    logic [31:0] add_a, wdata_a, rdata_a;
    logic [3:0]  be_a;
    logic [15:0] cnt_a;

    // Instance B: GntDelay=3, RspDelay=4
    logic        rst_b, req_b, we_b, gnt_b, r_valid_b, err_b;
    logic [31:0] add_b, wdata_b, rdata_b;
    logic [3:0]  be_b;
    logic [15:0] cnt_b;

    int tests    = 0;
    int failures = 0;

    dm_sba_responder #(.BusWidth(32), .MemDepth(16), .GntDelay(0), .RspDelay(1)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .slave_req_i(req_a), .slave_add_i(add_a),
        .slave_we_i(we_a), .slave_wdata_i(wdata_a), .slave_be_i(be_a),
        .slave_gnt_o(gnt_a), .slave_r_valid_o(r_valid_a), .slave_r_rdata_o(rdata_a),
        .slave_err_o(err_a), .txn_count_o(cnt_a)
    );

    dm_sba_responder #(.BusWidth(32), .MemDepth(16), .GntDelay(3), .RspDelay(4)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .slave_req_i(req_b), .slave_add_i(add_b),
        .slave_we_i(we_b), .slave_wdata_i(wdata_b), .slave_be_i(be_b),
        .slave_gnt_o(gnt_b), .slave_r_valid_o(r_valid_b), .slave_r_rdata_o(rdata_b),
        .slave_err_o(err_b), .txn_count_o(cnt_b)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One transaction on A: grant in the request cycle, response one cycle later.
    task automatic txn_a(input int n, input vec_t v);
        @(negedge clk);
        req_a = 1'b1; we_a = v.we; add_a = v.addr; wdata_a = v.wdata; be_a = v.be;
        #1;
        check($sformatf("vec%0d gnt", n), gnt_a, 1'b1);
        check($sformatf("vec%0d idle r_valid", n), r_valid_a, 1'b0);
        @(negedge clk);
        req_a = 1'b0;
        #1;
        check($sformatf("vec%0d r_valid", n), r_valid_a, 1'b1);
        check($sformatf("vec%0d rdata", n), rdata_a, v.exp_rdata);
        check($sformatf("vec%0d err", n), err_a, v.exp_err);
        check($sformatf("vec%0d txn_count", n), cnt_a, 16'(n + 1));
        $display("[TB] A vec%0d we=%0d addr=0x%0h rdata=0x%0h err=%0d", n, v.we, v.addr, rdata_a, err_a);
    endtask

    // One transaction on B with bounded waits; measures grant and response latency.
    task automatic txn_b(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input logic exp_err);
        int k;
        @(negedge clk);
        req_b = 1'b1; we_b = we; add_b = addr; wdata_b = wdata; be_b = be;
        k = 0;
        #1;
        while (!gnt_b && k < 20) begin @(negedge clk); #1; k++; end
        check({name, " gnt latency"}, 64'(k), 64'd3);
        @(negedge clk);
        req_b = 1'b0;
        k = 1;
        #1;
        while (!r_valid_b && k < 20) begin @(negedge clk); #1; k++; end
        check({name, " rsp latency"}, 64'(k), 64'd4);
        check({name, " rdata"}, rdata_b, exp_rdata);
        check({name, " err"}, err_b, exp_err);
        $display("[TB] B %s we=%0d addr=0x%0h rdata=0x%0h err=%0d", name, we, addr, rdata_b, err_b);
    endtask

    initial begin
        int k;
        vecs[0]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 32'h04, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h04, 32'h000000AA, 4'h1, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h04, 32'h0,        4'hF, 32'hDEADBEAA, 1'b0};
        vecs[5]  = '{1'b1, 32'h40, 32'h12345678, 4'hF, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'h40, 32'h0,        4'hF, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'h00, 32'h0,        4'hF, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 32'h3C, 32'h0,        4'hF, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 32'h3C, 32'h11223344, 4'h0, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 32'h3C, 32'h0,        4'hF, 32'h0,        1'b0};
        vecs[11] = '{1'b1, 32'h3D, 32'hCAFEF00D, 4'hC, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 32'h3C, 32'h0,        4'hF, 32'hCAFE0000, 1'b0};
        vecs[13] = '{1'b0, 32'h3F, 32'h0,        4'h0, 32'hCAFE0000, 1'b0};

        rst_a = 1'b1; req_a = 1'b0; we_a = 1'b0; add_a = '0; wdata_a = '0; be_a = '0;
        rst_b = 1'b1; req_b = 1'b0; we_b = 1'b0; add_b = '0; wdata_b = '0; be_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset gnt", gnt_a, 1'b0);
        check("reset r_valid", r_valid_a, 1'b0);
        check("reset err", err_a, 1'b0);
        check("reset rdata", rdata_a, 32'h0);
        check("reset txn_count", cnt_a, 16'h0);
        check("reset txn_count B", cnt_b, 16'h0);
        rst_a = 1'b0; rst_b = 1'b0;

        for (int i = 0; i < 14; i++) txn_a(i, vecs[i]);

        // Request held through back-to-back reads: grants only on alternate cycles.
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b0; add_a = 32'h04; be_a = 4'hF;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("b2b gnt c%0d", i), gnt_a, (i % 2) == 0);
            check($sformatf("b2b r_valid c%0d", i), r_valid_a, (i % 2) == 1);
            check($sformatf("b2b rdata c%0d", i), rdata_a, ((i % 2) == 1) ? 32'hDEADBEAA : 32'h0);
            $display("[TB] A b2b cycle %0d gnt=%0d r_valid=%0d", i, gnt_a, r_valid_a);
            @(negedge clk);
        end
        req_a = 1'b0;
        #1;
        check("b2b txn_count", cnt_a, 16'd17);

        // Latency: grant 3 cycles after req rises, r_valid 4 cycles after grant.
        txn_b("lat read", 1'b0, 32'h04, 32'h0, 4'hF, 32'h0, 1'b0);
        check("lat txn_count", cnt_b, 16'd1);

        // Request dropped during the stall: never granted.
        @(negedge clk);
        req_b = 1'b1; we_b = 1'b0; add_b = 32'h04;
        #1;
        check("drop gnt c0", gnt_b, 1'b0);
        @(negedge clk);
        req_b = 1'b0;
        for (int i = 1; i < 6; i++) begin
            #1;
            check($sformatf("drop gnt c%0d", i), gnt_b, 1'b0);
            @(negedge clk);
        end
        check("drop txn_count", cnt_b, 16'd1);
        $display("[TB] B dropped request txn_count=%0d", cnt_b);

        txn_b("write 0x8", 1'b1, 32'h08, 32'h55AA55AA, 4'hF, 32'h0, 1'b0);

        // Reset while responding, before r_valid.
        @(negedge clk);
        req_b = 1'b1; we_b = 1'b0; add_b = 32'h08;
        k = 0;
        #1;
        while (!gnt_b && k < 20) begin @(negedge clk); #1; k++; end
        check("midrst gnt latency", 64'(k), 64'd3);
        @(negedge clk);
        req_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("midrst r_valid c%0d", i), r_valid_b, 1'b0);
            @(negedge clk);
        end
        check("midrst txn_count", cnt_b, 16'd0);
        $display("[TB] B reset mid-response txn_count=%0d", cnt_b);
        txn_b("read after rst", 1'b0, 32'h08, 32'h0, 4'hF, 32'h0, 1'b0);
        check("post rst txn_count", cnt_b, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
